key_pio_irq: RTL and testbench

KEY_PIO_IRQ -- requirements
Module: key_pio_irq

---
 rtl/key_pio_irq.sv | 113 +++++++++++
 tb/tb_key_pio_irq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_pio_irq.sv
// Key input PIO: synchronised inputs, per-bit edge capture with W1C clear and a level interrupt.
// Define KEY_PIO_DEBOUNCE_EN to add a per-bit debounce filter of DEBOUNCE_CYCLES clocks.
module key_pio_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned IDLE_LEVEL      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IdleVec = (IDLE_LEVEL != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_sel_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] edgecapture_q;
    logic [WIDTH-1:0] edgecapture_d;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      readdata_d;
    logic             wr;
    logic             unused_cfg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= IdleVec;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [WIDTH-1:0] stable_q;

    // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= IdleVec;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (synced[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntMax) begin
                    stable_q[i] <= synced[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign stable = stable_q;
`else
    assign stable = synced;
`endif

    assign wr         = chipselect & ~write_n;
    assign unused_cfg = (^writedata) ^ (DEBOUNCE_CYCLES == 0);

    always_comb begin
        cap_set       = (stable & ~prev_q & edge_sel_q) | (~stable & prev_q & ~edge_sel_q);
        cap_clr       = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        // Set wins over a simultaneous clear.
        edgecapture_d = (edgecapture_q & ~cap_clr) | cap_set;
        readdata_d    = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable;
            2'd1:    readdata_d[WIDTH-1:0] = edge_sel_q;
            2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
            default: readdata_d[WIDTH-1:0] = edgecapture_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q        <= IdleVec;
            edge_sel_q    <= '0;
            irqmask_q     <= '0;
            edgecapture_q <= '0;
            readdata      <= '0;
        end else begin
            prev_q        <= stable;
            edgecapture_q <= edgecapture_d;
            readdata      <= readdata_d;
            if (wr && address == 2'd1) edge_sel_q <= writedata[WIDTH-1:0];
            if (wr && address == 2'd2) irqmask_q  <= writedata[WIDTH-1:0];
        end
    end

    assign irq = |(edgecapture_q & irqmask_q);

endmodule

// File: tb/tb_key_pio_irq.sv
// Self-checking bench for key_pio_irq: directed scenarios plus random traffic vs a queue-based model.
module tb_key_pio_irq;

    localparam int unsigned W = 4;
    localparam int unsigned S = 2;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int unsigned DB  = 8;
    localparam int unsigned LAT = S + DB;
`else
    localparam int unsigned DB  = 50000;
    localparam int unsigned LAT = S;
`endif
    localparam logic [W-1:0] IDLE = 4'hF;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'd0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port    = IDLE;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit [W-1:0]  m_hist[$];
    bit [W-1:0]  m_stable, m_prev, m_esel, m_mask, m_cap;
    bit [31:0]   m_rd;
`ifdef KEY_PIO_DEBOUNCE_EN
    bit [W-1:0]  m_win[$];
`endif

    key_pio_irq #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .IDLE_LEVEL     (1),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < int'(S); i++) m_hist.push_back(IDLE);
        m_stable = IDLE;
        m_prev   = IDLE;
        m_esel   = '0;
        m_mask   = '0;
        m_cap    = '0;
        m_rd     = '0;
`ifdef KEY_PIO_DEBOUNCE_EN
        m_win.delete();
`endif
    endtask

    // One clock: advance the model across the edge, then compare readdata and irq.
    task automatic step();
        bit [W-1:0] sel;
        bit [W-1:0] clr;
        bit         wr;
`ifdef KEY_PIO_DEBOUNCE_EN
        bit [W-1:0] syn_pre;
        syn_pre = m_hist[0];
`endif
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        // A captured bit changed and its new level equals the selected edge polarity.
        sel = (m_stable ^ m_prev) & ~(m_stable ^ m_esel);
        m_rd = 32'd0;
        case (address)
            2'd0:    m_rd = {28'd0, m_stable};
            2'd1:    m_rd = {28'd0, m_esel};
            2'd2:    m_rd = {28'd0, m_mask};
            default: m_rd = {28'd0, m_cap};
        endcase
        m_cap  = (m_cap & ~clr) | sel;
        m_prev = m_stable;
        if (wr && address == 2'd1) m_esel = writedata[W-1:0];
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        m_hist.push_back(in_port);
        void'(m_hist.pop_front());
`ifdef KEY_PIO_DEBOUNCE_EN
        m_win.push_back(syn_pre);
        if (m_win.size() > DB) void'(m_win.pop_front());
        if (m_win.size() == DB) begin
            for (int b = 0; b < int'(W); b++) begin
                bit flip;
                flip = 1'b1;
                foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) flip = 1'b0;
                if (flip) m_stable[b] = ~m_stable[b];
            end
        end
`else
        m_stable = m_hist[0];
`endif
        @(posedge clk);
        @(negedge clk);
        check("model_rd", readdata, m_rd);
        check("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        step();
        check(tag, readdata, exp);
    endtask

    task automatic do_reset();
        chipselect = 1'b0;
        write_n    = 1'b1;
        in_port    = IDLE;
        #2 reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Idle inputs after reset: only the data register reflects the idle level.
        for (int a = 0; a < 4; a++) read_check("rst_read", 2'(a), (a == 0) ? 32'hF : 32'h0);

        // Falling edge on bit0 with irqmask bit0 set.
        bus_write(2'd2, 32'h1);
        address = 2'd3;
        in_port = 4'hE;
        steps(int'(LAT));
        check("irq_before_capture", {31'd0, irq}, 32'd0);
        step();
        check("irq_after_capture", {31'd0, irq}, 32'd1);
        read_check("cap_bit0", 2'd3, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_after_clear", {31'd0, irq}, 32'd0);
        read_check("cap_cleared", 2'd3, 32'h0);

        // Rising-edge selection on bit1: the press is ignored, the release captured.
        in_port = 4'hF;
        steps(int'(LAT) + 2);
        bus_write(2'd1, 32'h2);
        in_port = 4'hD;
        steps(int'(LAT) + 2);
        read_check("bit1_fall_ignored", 2'd3, 32'h0);
        in_port = 4'hF;
        steps(int'(LAT) + 2);
        read_check("bit1_rise_captured", 2'd3, 32'h2);

        // Clear write landing on the same edge as a new capture: the set wins.
        bus_write(2'd3, 32'hF);
        bus_write(2'd1, 32'h0);
        in_port = 4'hE;
        steps(int'(LAT));
        bus_write(2'd3, 32'h1);
        read_check("set_beats_clear", 2'd3, 32'h1);

        // Random traffic against the model.
        bus_write(2'd3, 32'hF);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ (4'd1 << $urandom_range(0, W - 1));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom();
            step();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

`ifdef KEY_PIO_DEBOUNCE_EN
        // Bouncing bit0 must produce exactly one qualified change after it settles.
        begin
            int   changes;
            int   first;
            logic last;
            do_reset();
            address = 2'd0;
            step();
            changes = 0;
            first   = -1;
            last    = readdata[0];
            for (int r = 0; r < 5; r++) begin
                for (int k = 0; k < 6; k++) begin
                    in_port = (k < 3) ? 4'hE : 4'hF;
                    step();
                    if (readdata[0] != last) begin
                        changes++;
                        last = readdata[0];
                    end
                end
            end
            in_port = 4'hE;
            for (int k = 1; k <= 40; k++) begin
                step();
                if (readdata[0] != last) begin
                    changes++;
                    last = readdata[0];
                    if (first < 0) first = k;
                end
            end
            check("db_latency", first, S + DB + 1);
            check("db_changes", changes, 1);
            read_check("db_single_capture", 2'd3, 32'h1);
        end
`endif

        // Reset while interrupts are pending must drop irq without waiting for a clock.
        do_reset();
        bus_write(2'd2, 32'hF);
        in_port = 4'h0;
        steps(int'(LAT) + 2);
        read_check("all_captured", 2'd3, 32'hF);
        check("irq_all_pending", {31'd0, irq}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("irq_async_drop", {31'd0, irq}, 32'd0);
        check("readdata_async_clear", readdata, 32'd0);
        in_port = IDLE;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) read_check("post_rst_read", 2'(a), (a == 0) ? 32'hF : 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
